// File: rtl/dac80004_pkg.sv
// Shared definitions for the DAC80004 SPI writer: state encoding, frame width and
// DAC command codes used by benches and software-side word generators.
package dac80004_pkg;

  localparam int unsigned FRAME_BITS = 32;

  // DAC80004 command field values (bits [27:24] of the command word).
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftLo,
    StShiftHi,
    StGapWait,
    StArm
  } dac_state_t;

endpackage

// File: rtl/spi_half_tick.sv
// Phase timer for the SPI writer. A down-counter reloaded on every state entry;
// tick is high while the count is zero, i.e. in the last cycle of a phase.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   load         : reload the counter with load_val this cycle
//   load_val     : phase length minus one
//   tick         : phase-done indication
module spi_half_tick #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/dac80004_spi_writer.sv
// Serializes 32-bit DAC80004 command words MSB first onto sclk/sync_n/sdi and
// returns a one-cycle fetch_enable pulse once the frame and inter-frame gap are done.
// Ports:
//   clk, reset_n      : clock and asynchronous active-low reset
//   data, data_valid  : word from the fetch stage, sampled only in IDLE
//   fetch_enable      : one-cycle re-arm pulse to the fetch stage
//   busy              : high whenever not IDLE
//   overrun           : sticky, set by data_valid while busy
//   sclk, sync_n, sdi : DAC SPI pins (sclk idles high)
module dac80004_spi_writer
  import dac80004_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned GAP     = 2,
  parameter int unsigned N       = FRAME_BITS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] data,
  input  logic         data_valid,
  output logic         fetch_enable,
  output logic         busy,
  output logic         overrun,
  output logic         sclk,
  output logic         sync_n,
  output logic         sdi
);

  localparam int unsigned TW = 16;
  localparam int unsigned BW = $clog2(N);

  dac_state_t    state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          sclk_q, sclk_d;
  logic          sync_q, sync_d;
  logic          fe_q, fe_d;
  logic          busy_q;
  logic          ovr_q;

  logic          tick;
  logic          load;
  logic [TW-1:0] load_val;

  // Timer restarts on every state change; the gap phase reuses it with its own length.
  assign load     = (state_d != state_q);
  assign load_val = (state_d == StGapWait) ? TW'(GAP - 1) : TW'(CLK_DIV - 1);

  spi_half_tick #(
    .W (TW)
  ) u_half_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .tick     (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    sync_d  = sync_q;
    fe_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (data_valid) begin
          shift_d = data;
          sync_d  = 1'b0;
          bit_d   = BW'(N - 1);
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (tick) begin
          sclk_d  = 1'b0;
          state_d = StShiftLo;
        end
      end
      StShiftLo: begin
        // Next bit is presented on the rising edge, a full phase before the DAC samples it.
        if (tick) begin
          sclk_d = 1'b1;
          if (bit_q != '0) begin
            shift_d = shift_q << 1;
          end
          state_d = StShiftHi;
        end
      end
      StShiftHi: begin
        if (tick) begin
          if (bit_q != '0) begin
            bit_d   = bit_q - 1'b1;
            sclk_d  = 1'b0;
            state_d = StShiftLo;
          end else begin
            // Final high phase doubles as the DAC's SYNC hold time.
            sync_d  = 1'b1;
            shift_d = '0;
            state_d = StGapWait;
          end
        end
      end
      StGapWait: begin
        if (tick) begin
          fe_d    = 1'b1;
          state_d = StArm;
        end
      end
      StArm: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b1;
      sync_q  <= 1'b1;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      sync_q  <= sync_d;
      fe_q    <= fe_d;
      busy_q  <= (state_d != StIdle);
      ovr_q   <= ovr_q | (data_valid & busy_q);
    end
  end

  assign fetch_enable = fe_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;
  assign sclk         = sclk_q;
  assign sync_n       = sync_q;
  assign sdi          = shift_q[N-1];

endmodule

// File: tb/tb_dac80004_spi_writer.sv
// Bench for dac80004_spi_writer: two instances (CLK_DIV=2/GAP=2 and CLK_DIV=1/GAP=1)
// observed by a pin-level DAC model that reassembles words on sclk falling edges.
module tb_dac80004_spi_writer;
  import dac80004_pkg::*;

  localparam int C0 = 2, G0 = 2, C1 = 1, G1 = 1;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic [31:0] data [2];
  logic        dv [2];
  logic        fe [2], busy [2], ovr [2], sclk [2], sync_n [2], sdi [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dac80004_spi_writer #(.CLK_DIV(C0), .GAP(G0), .N(32)) u_dut0 (
    .clk(clk), .reset_n(rst_n[0]), .data(data[0]), .data_valid(dv[0]),
    .fetch_enable(fe[0]), .busy(busy[0]), .overrun(ovr[0]),
    .sclk(sclk[0]), .sync_n(sync_n[0]), .sdi(sdi[0])
  );

  dac80004_spi_writer #(.CLK_DIV(C1), .GAP(G1), .N(32)) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]), .data(data[1]), .data_valid(dv[1]),
    .fetch_enable(fe[1]), .busy(busy[1]), .overrun(ovr[1]),
    .sclk(sclk[1]), .sync_n(sync_n[1]), .sdi(sdi[1])
  );

  // DAC-side observer
  int          frame_cnt [2] = '{0, 0};
  int          fetch_cnt [2] = '{0, 0};
  int          falls [2] = '{0, 0};
  int          last_falls [2] = '{0, 0};
  int          fall_cyc [2] = '{0, 0};
  int          last_low [2] = '{0, 0};
  int          last_fetch_cyc [2] = '{0, 0};
  int          sdi_viol [2] = '{0, 0};
  int          stray [2] = '{0, 0};
  int          double_fe [2] = '{0, 0};
  logic [31:0] acc [2] = '{32'h0, 32'h0};
  logic [31:0] last_word [2] = '{32'h0, 32'h0};
  logic        psclk [2] = '{1'b1, 1'b1};
  logic        psync [2] = '{1'b1, 1'b1};
  logic        psdi [2] = '{1'b0, 1'b0};
  logic        pfe [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (psync[i] && !sync_n[i]) begin
        fall_cyc[i] = cyc;
        falls[i]    = 0;
        acc[i]      = 32'h0;
      end
      if (psclk[i] && !sclk[i]) begin
        if (!sync_n[i]) begin
          falls[i]++;
          acc[i] = {acc[i][30:0], sdi[i]};
        end else begin
          stray[i]++;
        end
      end
      if ((sdi[i] !== psdi[i]) && !sclk[i]) sdi_viol[i]++;
      if (!psync[i] && sync_n[i]) begin
        last_word[i]  = acc[i];
        last_falls[i] = falls[i];
        last_low[i]   = cyc - fall_cyc[i];
        frame_cnt[i]++;
      end
      if (fe[i]) begin
        if (pfe[i]) double_fe[i]++;
        fetch_cnt[i]++;
        last_fetch_cyc[i] = cyc;
      end
      psclk[i] = sclk[i];
      psync[i] = sync_n[i];
      psdi[i]  = sdi[i];
      pfe[i]   = fe[i];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference timing from the frame rules: SETUP + 32 low/high pairs, then gap, then ARM.
  function automatic int cdiv(input int s);
    return (s == 0) ? C0 : C1;
  endfunction
  function automatic int gapc(input int s);
    return (s == 0) ? G0 : G1;
  endfunction

  task automatic wait_fetch(input int i, input int e0, input int bound, output bit got);
    got = 1'b0;
    for (int k = 0; k < bound && !got; k++) begin
      @(posedge clk); #2;
      if (fetch_cnt[i] != e0) got = 1'b1;
    end
  endtask

  task automatic run_word(input int i, input logic [31:0] w, input int exp_low,
                          input int exp_lat, input string tag);
    int f0, e0, c0;
    bit got;
    f0 = frame_cnt[i];
    e0 = fetch_cnt[i];
    @(posedge clk); #1;
    data[i] = w;
    dv[i]   = 1'b1;
    c0      = cyc;
    @(posedge clk); #1;
    dv[i]   = 1'b0;
    data[i] = $urandom;
    chk({tag, " busy"}, busy[i], 1);
    chk({tag, " sync_n"}, sync_n[i], 0);
    chk({tag, " first sdi"}, sdi[i], w[31]);
    wait_fetch(i, e0, exp_lat + 50, got);
    chk({tag, " fetch timeout"}, got, 1);
    chk({tag, " word"}, last_word[i], w);
    chk({tag, " falls"}, last_falls[i], 32);
    chk({tag, " sync low"}, last_low[i], exp_low);
    chk({tag, " sync latency"}, fall_cyc[i] - c0, 1);
    chk({tag, " fetch latency"}, last_fetch_cyc[i] - c0, exp_lat);
    chk({tag, " frames"}, frame_cnt[i] - f0, 1);
    chk({tag, " fetches"}, fetch_cnt[i] - e0, 1);
  endtask

  typedef struct {
    int          sel;
    logic [31:0] word;
    int          exp_low;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int f0, e0, c0;
    bit got;
    logic [31:0] cmd;

    vecs[0] = '{0, 32'hA5C3_0F1E, 130, 133};
    vecs[1] = '{0, 32'h0030_0000, 130, 133};
    vecs[2] = '{0, 32'h0031_FFFF, 130, 133};
    vecs[3] = '{0, 32'h0032_8000, 130, 133};
    vecs[4] = '{1, 32'hFFFF_FFFF, 65, 67};
    vecs[5] = '{1, 32'h8000_0001, 65, 67};
    for (int k = 6; k < 10; k++) begin
      cmd = $urandom;
      cmd[27:24] = (k % 3 == 0) ? CMD_POWER_DOWN : CMD_WRITE_UPDATE;
      vecs[k].sel     = k % 2;
      vecs[k].word    = cmd;
      vecs[k].exp_low = 65 * cdiv(k % 2);
      vecs[k].exp_lat = 65 * cdiv(k % 2) + gapc(k % 2) + 1;
    end

    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      data[i]  = 32'h0;
      dv[i]    = 1'b0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d sclk", i), sclk[i], 1);
      chk($sformatf("rst%0d sync_n", i), sync_n[i], 1);
      chk($sformatf("rst%0d sdi", i), sdi[i], 0);
      chk($sformatf("rst%0d fetch_enable", i), fe[i], 0);
      chk($sformatf("rst%0d busy", i), busy[i], 0);
      chk($sformatf("rst%0d overrun", i), ovr[i], 0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("idle%0d sclk edges", i), stray[i], 0);
      chk($sformatf("idle%0d fetches", i), fetch_cnt[i], 0);
      chk($sformatf("idle%0d frames", i), frame_cnt[i], 0);
    end

    // Table: entries 1..3 run back to back as the closed loop with the fetch stage
    for (int k = 0; k < 10; k++) begin
      run_word(vecs[k].sel, vecs[k].word, vecs[k].exp_low, vecs[k].exp_lat,
               $sformatf("vec%0d", k));
      if (k == 3) chk("loop overrun", ovr[0], 0);
    end

    // Overrun on dut1: second word at cycle 20 of a frame
    f0 = frame_cnt[1];
    e0 = fetch_cnt[1];
    @(posedge clk); #1;
    data[1] = 32'h1234_5678;
    dv[1]   = 1'b1;
    c0      = cyc;
    @(posedge clk); #1;
    dv[1]   = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("ovr inject cycle", cyc - c0, 20);
    data[1] = 32'hDEAD_BEEF;
    dv[1]   = 1'b1;
    @(posedge clk); #1;
    dv[1]   = 1'b0;
    chk("ovr flag set", ovr[1], 1);
    wait_fetch(1, e0, 200, got);
    chk("ovr fetch timeout", got, 1);
    chk("ovr word", last_word[1], 32'h1234_5678);
    chk("ovr falls", last_falls[1], 32);
    chk("ovr fetch latency", last_fetch_cyc[1] - c0, 67);
    repeat (150) @(posedge clk);
    #2;
    chk("ovr frames", frame_cnt[1] - f0, 1);
    chk("ovr fetches", fetch_cnt[1] - e0, 1);
    chk("ovr sticky", ovr[1], 1);
    rst_n[1] = 1'b0;
    #1;
    chk("ovr cleared by reset", ovr[1], 0);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;

    // Reset mid-frame on dut0 after the 10th falling edge
    e0 = fetch_cnt[0];
    @(posedge clk); #1;
    data[0] = 32'hC0FF_EE11;
    dv[0]   = 1'b1;
    @(posedge clk); #1;
    dv[0]   = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk); #2;
      if (falls[0] == 10) got = 1'b1;
    end
    chk("midrst reach 10th edge", got, 1);
    chk("midrst sclk low before", sclk[0], 0);
    #1;
    rst_n[0] = 1'b0;
    #1;
    chk("midrst sync_n", sync_n[0], 1);
    chk("midrst sclk", sclk[0], 1);
    chk("midrst busy", busy[0], 0);
    chk("midrst sdi", sdi[0], 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    repeat (200) @(posedge clk);
    #2;
    chk("midrst no fetch", fetch_cnt[0] - e0, 0);
    chk("midrst truncated falls", last_falls[0], 10);
    run_word(0, 32'h0033_ABCD, 130, 133, "after midrst");

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d sdi moved while sclk low", i), sdi_viol[i], 0);
      chk($sformatf("dut%0d sclk edges outside frame", i), stray[i], 0);
      chk($sformatf("dut%0d multi-cycle fetch_enable", i), double_fe[i], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac80004_spi_writer.md
# dac80004_spi_writer

Serializes 32-bit DAC80004 command words onto the DAC's SPI pins (sclk, sync_n, sdi). It sits directly downstream of the mSGDMA stream fetch stage and consumes its `data`/`data_valid` output. When a frame has gone out and the inter-frame gap has elapsed, it returns a one-cycle `fetch_enable` pulse, which re-arms the fetch stage for the next word. Words are sent MSB first and are not modified.

## Interface
- `CLK_DIV`, default 2: clk cycles per sclk half-period; legal range is 1 or more.
- `GAP`, default 2: clk cycles sync_n stays high after a frame, before `fetch_enable` fires; legal range is 1 or more.
- `N`, default 32: word width; fixed at 32 for the DAC80004.
- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `data` in N: word to transmit; sampled only when `data_valid` is high in IDLE.
- `data_valid` in 1: one-cycle strobe from the fetch stage.
- `fetch_enable` out 1: one-cycle pulse that re-arms the upstream fetch.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: sticky flag; set when `data_valid` arrives while `busy`; cleared only by reset.
- `sclk` out 1: SPI clock; idles high.
- `sync_n` out 1: DAC frame sync; active low.
- `sdi` out 1: serial data; changes only while sclk is high or on the frame-start edge.

## Operation
- States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, GAP_WAIT, ARM.
- Reset value of every output: `sclk`=1, `sync_n`=1, `sdi`=0, `fetch_enable`=0, `busy`=0, `overrun`=0. The state machine resets to IDLE and all counters reset to 0.
- IDLE, `data_valid`=1:
  - Load the shift register with `data`.
  - Drive `sdi` with `data[31]` and set `sync_n`=0.
  - Load the bit counter with 31 and go to SETUP.
- SETUP: hold for CLK_DIV cycles, then set `sclk`=0 and go to SHIFT_LO. The DAC samples `sdi` on this falling edge.
- SHIFT_LO: hold for CLK_DIV cycles, then set `sclk`=1 and go to SHIFT_HI.
  - If the bit counter is not 0, shift the register left on the same edge, so `sdi` takes the next bit.
  - If the bit counter is 0, do not shift.
- SHIFT_HI: hold for CLK_DIV cycles.
  - If the bit counter is not 0, decrement it, set `sclk`=0 and go to SHIFT_LO.
  - If the bit counter is 0, set `sync_n`=1 and `sdi`=0 and go to GAP_WAIT. This final high phase provides the DAC's SYNC hold time.
- GAP_WAIT: hold for GAP cycles, then go to ARM.
- ARM: drive `fetch_enable`=1 for exactly one cycle, then return to IDLE.
- `data_valid` while busy:
  - The word is ignored and the frame in flight is unaffected.
  - `overrun` is set to 1.
- `data_valid` in the ARM cycle also counts as an overrun.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). `sync_n` going high aborts the DAC frame; no `fetch_enable` pulse is issued.
- No word is ever transmitted twice, and no word is truncated except by reset.

## Timing
- Latency from `data_valid` to `sync_n` falling: 1 clk; `sync_n`, `sdi` and `busy` are registered on the sampling edge.
- `sync_n` stays low for exactly 65×CLK_DIV cycles: the SETUP phase plus 32 × (low phase + high phase).
- The frame contains exactly 32 sclk falling edges, and `sdi` is stable for CLK_DIV cycles on each side of every falling edge.
- The sclk period is 2×CLK_DIV clk cycles.
- The `fetch_enable` pulse is asserted in clk cycle 65×CLK_DIV + GAP + 1, counting the `data_valid` cycle as cycle 0.
- Minimum word-to-word period is 65×CLK_DIV + GAP + 2 cycles plus the upstream fetch latency.
- All outputs are registered; none has a combinational path from an input.

## Structure
- `dac80004_pkg` holds:
  - the state enum `dac_state_t`;
  - `FRAME_BITS`=32;
  - DAC80004 command localparams (write-and-update `4'b0011`, power-down `4'b0100`) for the benches and for software-side generators.
- One sub-module, `spi_half_tick`, a CLK_DIV down-counter producing a one-cycle phase-done tick. It is reloaded on every state entry and is also reused for the GAP count, with a runtime load value.

## Test plan
- Reset values: hold `reset_n`=0 → all outputs at their reset values; release, idle 100 cycles → no sclk edges and no `fetch_enable` pulse.
- Single word: CLK_DIV=2, GAP=2, `data`=0xA5C3_0F1E → `sync_n` low for 130 cycles with 32 falling sclk edges; the bits sampled on the falling edges reassemble 0xA5C3_0F1E; `fetch_enable` pulses at cycle 133.
- Closed loop with the fetch stage: three words 0x0030_0000, 0x0031_FFFF, 0x0032_8000 → three frames in order; `overrun` stays 0; exactly one `fetch_enable` per frame.
- Overrun: CLK_DIV=1, inject `data_valid` with 0xDEAD_BEEF at cycle 20 of a frame carrying 0x1234_5678 → 0x1234_5678 is transmitted intact, 0xDEAD_BEEF is never sent, and `overrun`=1 until the next reset.
- Reset mid-frame: assert `reset_n`=0 after the 10th falling sclk edge → `sync_n`=1 and `sclk`=1 in the same cycle, no `fetch_enable`; the next word is sent complete.
- Minimum settings: CLK_DIV=1, GAP=1, word 0xFFFF_FFFF → `sync_n` low for 65 cycles and `fetch_enable` at cycle 67; `sdi` is never sampled during a transition.
